// File: rtl/mult_div_unit_if.sv
// Handshake/operand bundle between the E stage and the HI/LO multiply/divide unit.
interface mult_div_unit_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        d_is_md;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, src_a, src_b, d_is_md,
        input  busy, stall_md, hi, lo
    );

    modport slave (
        input  start, md_op, src_a, src_b, d_is_md,
        output busy, stall_md, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Fixed-latency MULT/MULTU/DIV/DIVU unit owning HI/LO, with MTHI/MTLO writes and
// the stall_md freeze request for an md-class instruction waiting in D.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave md
);
    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic [63:0]        res_q, res_d;

    logic               start_calc, is_div, is_signed;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u, div_res, calc_res;
    logic               neg_a, neg_b;
    logic [31:0]        mag_a, mag_b, divisor, q_mag, r_mag, quot, rem;

    assign start_calc = md.start & (md.md_op <= 3'd3) & ~busy_q;
    assign is_div     = md.md_op[1];
    assign is_signed  = ~md.md_op[0];

    assign prod_s = $signed({{32{md.src_a[31]}}, md.src_a}) * $signed({{32{md.src_b[31]}}, md.src_b});
    assign prod_u = {32'd0, md.src_a} * {32'd0, md.src_b};

    // Signed divide on magnitudes: 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign neg_a   = is_signed & md.src_a[31];
    assign neg_b   = is_signed & md.src_b[31];
    assign mag_a   = neg_a ? (32'd0 - md.src_a) : md.src_a;
    assign mag_b   = neg_b ? (32'd0 - md.src_b) : md.src_b;
    assign divisor = (md.src_b == 32'd0) ? 32'd1 : mag_b;
    assign q_mag   = mag_a / divisor;
    assign r_mag   = mag_a % divisor;
    assign quot    = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
    assign rem     = neg_a ? (32'd0 - r_mag) : r_mag;
    assign div_res = (md.src_b == 32'd0) ? {md.src_a, 32'hFFFF_FFFF} : {rem, quot};

    assign calc_res = is_div ? div_res : (is_signed ? unsigned'(prod_s) : prod_u);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (start_calc) begin
                    res_d  = calc_res;
                    busy_d = 1'b1;
                    if (is_div) begin
                        state_d = DIV;
                        cnt_d   = CNT_W'(DIV_CYCLES - 1);
                    end else begin
                        state_d = MUL;
                        cnt_d   = CNT_W'(MULT_CYCLES - 1);
                    end
                end else if (md.start && !busy_q) begin
                    if (md.md_op == 3'd4) hi_d = md.src_a;
                    if (md.md_op == 3'd5) lo_d = md.src_a;
                end
            end
            MUL, DIV: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    hi_d    = res_q[63:32];
                    lo_d    = res_q[31:0];
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
        end
    end

    assign md.busy     = busy_q;
    assign md.stall_md = md.d_is_md & (busy_q | start_calc);
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus randomized checks of mult_div_unit against an arithmetic HI/LO model.
module tb_mult_div_unit;
    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mult_div_unit_if bus ();

    mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] hi_m   = '0;
    logic [31:0] lo_m   = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {hi, lo} an instruction should leave behind, straight from the ISA definition.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int                sa = a;
        int                sb = b;
        longint            ps;
        longint unsigned   pu;
        case (op)
            3'd0: begin ps = longint'(sa) * longint'(sb); return ps; end
            3'd1: begin pu = longint'(a) * longint'(b); return pu; end
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return {hi_m, lo_m};
        endcase
    endfunction

    // Called at posedge+1: issues op in this cycle and follows it to completion.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit d_md, input bit scramble, input bit mtlo_mid);
        logic [63:0] exp;
        int unsigned n;
        bus.start   = 1'b1;
        bus.md_op   = op;
        bus.src_a   = a;
        bus.src_b   = b;
        bus.d_is_md = d_md;
        #1;
        check("stall_at_start", 32'(bus.stall_md), 32'(d_md && op <= 3'd3));
        check("idle_before_start", 32'(bus.busy), 32'd0);
        exp = ref_result(op, a, b);
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (scramble) begin
            bus.src_a = $urandom;
            bus.src_b = $urandom;
        end
        if (op <= 3'd3) begin
            n = (op >= 3'd2) ? DIV_N : MULT_N;
            for (int k = 1; k <= int'(n); k++) begin
                if (mtlo_mid && k == 2) begin
                    bus.start = 1'b1;
                    bus.md_op = 3'd5;
                    bus.src_a = $urandom;
                end
                if (mtlo_mid && k == 3) bus.start = 1'b0;
                #1;
                check("busy_held", 32'(bus.busy), 32'd1);
                check("stall_while_busy", 32'(bus.stall_md), 32'(d_md));
                check("hi_held", bus.hi, hi_m);
                check("lo_held", bus.lo, lo_m);
                @(posedge clk); #1;
            end
            {hi_m, lo_m} = exp;
            check("busy_done", 32'(bus.busy), 32'd0);
            check("stall_done", 32'(bus.stall_md), 32'd0);
        end else begin
            if (op == 3'd4) hi_m = a;
            if (op == 3'd5) lo_m = a;
            check("busy_mt_mf", 32'(bus.busy), 32'd0);
        end
        check("hi_result", bus.hi, hi_m);
        check("lo_result", bus.lo, lo_m);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int unsigned r;

        bus.start   = 1'b0;
        bus.md_op   = 3'd0;
        bus.src_a   = '0;
        bus.src_b   = '0;
        bus.d_is_md = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_stall", 32'(bus.stall_md), 32'd0);
        check("reset_hi", bus.hi, 32'd0);
        check("reset_lo", bus.lo, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, 1'b0);
        check("mult_hi", bus.hi, 32'hFFFF_FFFF);
        check("mult_lo", bus.lo, 32'hFFFF_FFFA);
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 1'b0);
        check("multu_hi", bus.hi, 32'h0000_0002);
        check("multu_lo", bus.lo, 32'hFFFF_FFFA);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b0);
        check("div_hi", bus.hi, 32'hFFFF_FFFF);
        check("div_lo", bus.lo, 32'hFFFF_FFFD);
        run_op(3'd3, 32'd7, 32'd2, 1'b0, 1'b0, 1'b0);
        check("divu_hi", bus.hi, 32'd1);
        check("divu_lo", bus.lo, 32'd3);
        run_op(3'd2, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0);
        check("div0_hi", bus.hi, 32'd5);
        check("div0_lo", bus.lo, 32'hFFFF_FFFF);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        check("div_ovf_hi", bus.hi, 32'd0);
        check("div_ovf_lo", bus.lo, 32'h8000_0000);
        run_op(3'd4, 32'h0000_1234, 32'd0, 1'b1, 1'b0, 1'b0);
        check("mthi", bus.hi, 32'h0000_1234);
        run_op(3'd0, $urandom, $urandom, 1'b1, 1'b1, 1'b1);

        // Abort a divide at its third busy cycle.
        bus.start   = 1'b1;
        bus.md_op   = 3'd2;
        bus.src_a   = 32'd100;
        bus.src_b   = 32'd7;
        bus.d_is_md = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("div_busy_c3", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        hi_m  = '0;
        lo_m  = '0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        run_op(3'd0, 32'd2, 32'd3, 1'b1, 1'b0, 1'b0);
        check("post_abort_lo", bus.lo, 32'd6);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            r  = $urandom_range(0, 9);
            if (r == 0) b = '0;
            if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (r == 2) begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
            run_op(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
